// File: rtl/counter_up_down.sv
// counter_up_down: up/down binary counter with parallel load and registered wrap pulse
module counter_up_down #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             rollover
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);
  logic [WIDTH-1:0] count_q, count_d;
  logic             rollover_q, rollover_d;
  // next state: reset beats load, load beats stepping; a wrap is flagged only when stepping
  always_comb begin
    count_d    = rstn ? RST : load_en ? load : down ? count_q - 1'b1 : count_q + 1'b1;
    rollover_d = !rstn && !load_en && (down ? count_q == '0 : count_q == MAX);
  end
  // state register; both outputs come straight from flops
  always_ff @(posedge clk) begin
    count_q    <= count_d;
    rollover_q <= rollover_d;
  end
  assign count    = count_q;
  assign rollover = rollover_q;
`ifndef SYNTHESIS
  logic chk_q = 1'b0;
  // arms the checks once a reset edge has made history well defined
  always_ff @(posedge clk) chk_q <= chk_q | rstn;
  a_step: assert property (@(posedge clk) chk_q |->
    count == WIDTH'($past(count) + 1'b1) || count == WIDTH'($past(count) - 1'b1) ||
    ($past(load_en) && count == $past(load)) || ($past(rstn) && count == RST));
  a_wrap_val: assert property (@(posedge clk) chk_q && rollover |-> count == '0 || count == MAX);
  a_no_wrap_after_ld: assert property (@(posedge clk) chk_q && ($past(rstn) || $past(load_en)) |-> !rollover);
`endif
endmodule

// File: tb/tb_counter_up_down.sv
// tb_counter_up_down: directed and randomised checks of counter_up_down at widths 4, 1 and 8
module tb_counter_up_down;
  logic        clk = 1'b0;
  logic        rstn = 1'b1, load_en = 1'b0, down = 1'b0;
  logic [31:0] ld = '0;
  logic [3:0]  count4;
  logic [0:0]  count1;
  logic [7:0]  count8;
  logic        ro4, ro1, ro8;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] m4, m1, m8;
  logic        r4, r1, r8, mv = 1'b0;
  always #10 clk = ~clk;
  counter_up_down #(.WIDTH(4)) dut4 (.clk(clk), .rstn(rstn), .load_en(load_en), .load(ld[3:0]),
    .down(down), .count(count4), .rollover(ro4));
  counter_up_down #(.WIDTH(1)) dut1 (.clk(clk), .rstn(rstn), .load_en(load_en), .load(ld[0:0]),
    .down(down), .count(count1), .rollover(ro1));
  counter_up_down #(.WIDTH(8)) dut8 (.clk(clk), .rstn(rstn), .load_en(load_en), .load(ld[7:0]),
    .down(down), .count(count8), .rollover(ro8));
  function automatic logic [32:0] step(int w, logic [31:0] c);
    logic [31:0] mask = (32'd1 << w) - 1;
    if (rstn) return 33'd0;
    if (load_en) return {1'b0, ld & mask};
    if (down) return {c == 0, (c - 1) & mask};
    return {c == mask, (c + 1) & mask};
  endfunction
  always @(posedge clk) begin
    {r4, m4} <= step(4, m4);
    {r1, m1} <= step(1, m1);
    {r8, m8} <= step(8, m8);
    if (rstn) mv <= 1'b1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [3:0] ec, input logic er, input string tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, " count"}, {28'd0, count4}, {28'd0, ec});
    check({tag, " rollover"}, {31'd0, ro4}, {31'd0, er});
  endtask
  initial begin
    @(negedge clk);
    rstn = 1; load_en = 1; ld = 32'hA; down = 0;
    repeat (5) cyc(4'h0, 0, "reset");
    rstn = 0; load_en = 0;
    cyc(4'h1, 0, "post_rst1"); cyc(4'h2, 0, "post_rst2"); cyc(4'h3, 0, "post_rst3");
    load_en = 1; ld = 32'hE; cyc(4'hE, 0, "ld_E");
    load_en = 0; down = 0;
    cyc(4'hF, 0, "up_F"); cyc(4'h0, 1, "up_wrap"); cyc(4'h1, 0, "up_after");
    load_en = 1; ld = 32'h1; cyc(4'h1, 0, "ld_1");
    load_en = 0; down = 1;
    cyc(4'h0, 0, "dn_0"); cyc(4'hF, 1, "dn_wrap"); cyc(4'hE, 0, "dn_after");
    load_en = 1; ld = 32'h4; down = 0; cyc(4'h4, 0, "ld_4");
    load_en = 0; cyc(4'h5, 0, "up_5");
    load_en = 1; ld = 32'hC; down = 1; cyc(4'hC, 0, "ld_prio");
    load_en = 0; cyc(4'hB, 0, "dn_B");
    load_en = 1; ld = 32'hF; down = 0; cyc(4'hF, 0, "ld_max");
    load_en = 0; down = 1; cyc(4'hE, 0, "dir_chg");
    load_en = 1; ld = 32'h0; cyc(4'h0, 0, "ld_zero");
    ld = 32'h6; down = 0; cyc(4'h6, 0, "ld_6");
    load_en = 0; cyc(4'h7, 0, "up_7");
    rstn = 1; load_en = 1; cyc(4'h0, 0, "mid_rst");
    rstn = 0; load_en = 0; cyc(4'h1, 0, "resume1"); cyc(4'h2, 0, "resume2");
    rstn = 1; cyc(4'h0, 0, "rand_rst");
    fork
      repeat (150) begin
        #($urandom_range(1, 30));
        if ($time % 20 == 10) #1;
        rstn = ($urandom_range(0, 15) == 0);
        load_en = ($urandom_range(0, 3) == 0);
        down = $urandom_range(0, 1) == 1;
        ld = $urandom;
      end
      repeat (120) begin
        @(negedge clk);
        if (mv) begin
          check("rnd w4 count", {28'd0, count4}, m4);
          check("rnd w4 rollover", {31'd0, ro4}, {31'd0, r4});
          check("rnd w1 count", {31'd0, count1}, m1);
          check("rnd w1 rollover", {31'd0, ro1}, {31'd0, r1});
          check("rnd w8 count", {24'd0, count8}, m8);
          check("rnd w8 rollover", {31'd0, ro8}, {31'd0, r8});
        end
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/counter_up_down.md
Name:
counter_up_down

Overview:
- Parameterised synchronous up/down binary counter with parallel load and a wrap indicator.
- Used as a general-purpose event/position counter in datapath blocks.
- Driven from the standard counter interface bundle: clk, rstn, load_en, load, down, count, rollover.

Parameters:
- WIDTH, 4, bit width of load and count; legal range 1..32.
- RESET_VAL, 0, value loaded into count on reset; must fit in WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rstn  input  1  reset: one clock; reset is synchronous and active-high (rstn=1 resets on the next rising clk edge).
- load_en  input  1  parallel-load request, sampled at the rising edge.
- load  input  WIDTH  value written to count when load_en=1.
- down  input  1  direction: 0 = increment, 1 = decrement.
- count  output  WIDTH  registered counter value.
- rollover  output  1  registered one-cycle pulse indicating that count wrapped on the last edge.

Behaviour:
- Every rising clk edge is evaluated with strict priority: reset, then load, then count. There is no idle state; the counter steps every cycle unless reset or loading.
- Reset (rstn=1): count <= RESET_VAL and rollover <= 0, regardless of load_en or down. Reset asserted mid-count takes effect at the next edge, and the counter resumes from RESET_VAL on the first edge after rstn returns to 0.
- Load (rstn=0, load_en=1): count <= load and rollover <= 0. down is ignored in that cycle. A load value equal to 0 or MAX (2^WIDTH-1) does not set rollover.
- Count up (rstn=0, load_en=0, down=0): count <= count+1 modulo 2^WIDTH.
- Count down (rstn=0, load_en=0, down=1): count <= count-1 modulo 2^WIDTH.
- rollover:
  - Set to 1 on the edge where count steps MAX->0 while counting up, or 0->MAX while counting down.
  - Set to 0 on every other edge.
  - It is asserted in exactly the cycle where the wrapped value is visible on count.
- Direction change: takes effect on the next edge with no bubble. Example: count=MAX with down toggling 0->1 gives count MAX-1 and no rollover.
- All arithmetic is unsigned and truncated to WIDTH bits; there is no saturation.
- Outputs are registered only, with no combinational path from inputs to count or rollover.
- Inputs are X-free after reset; behaviour before the first reset edge is undefined (no power-on guarantee).
- Include synthesizable-guarded assertions:
  - count stable-plus-or-minus-1 or loaded or reset;
  - rollover implies count is 0 or MAX;
  - rollover never asserted the cycle after a load or reset.

Test Plan:
- Reset: hold rstn=1 for 5 cycles with load_en=1 and load=0xA -> count=0x0 and rollover=0 on every cycle. After release with down=0 -> count 0x1, 0x2, 0x3 on successive edges.
- Up wrap: load 0xE, then down=0 -> count 0xF (rollover=0), then 0x0 (rollover=1), then 0x1 (rollover=0).
- Down wrap: load 0x1, then down=1 -> count 0x0 (rollover=0), then 0xF (rollover=1), then 0xE (rollover=0).
- Load priority: count=0x5 counting up, apply load_en=1 with load=0xC and down=1 for one cycle -> count=0xC with rollover=0. Next edge with load_en=0 and down=1 -> 0xB.
- Reset mid-operation: counting at 0x7, assert rstn=1 together with load_en=1 -> count=0x0 and rollover=0. Deassert rstn -> counting resumes from 0x0.
- Random: 5+ iterations of randomised load/load_en/down, changed at random 1-30 ns offsets relative to a 20 ns clock. The scoreboard model must match count and rollover every cycle; also run with WIDTH=1 and WIDTH=8.
